// File: rtl/ahb_lite_sram_subordinate_pkg.sv
// Shared AHB-lite widths and encodings, plus the state type of the SRAM subordinate FSM.
package ahb_lite_sram_subordinate_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int TRANS_WIDTH = 2;
    localparam int SIZE_WIDTH  = 3;
    localparam int BURST_WIDTH = 3;
    localparam int PROT_WIDTH  = 4;
    localparam int RESP_WIDTH  = 1;
    localparam int READY_WIDTH = 1;

    typedef enum logic [TRANS_WIDTH-1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } HTRANS_e;

    typedef enum logic [SIZE_WIDTH-1:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } HSIZE_e;

    typedef enum logic [RESP_WIDTH-1:0] {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } HRESP_e;

    typedef enum logic [READY_WIDTH-1:0] {
        HREADY_WAIT  = 1'b0,
        HREADY_READY = 1'b1
    } HREADY_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } sram_state_e;

    // Little-endian byte-lane enables for a legal access size.
    function automatic logic [3:0] lane_enables(input logic [SIZE_WIDTH-1:0] size,
                                                input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: lane_enables = 4'b0001 << lane;
            HSIZE_HALF: lane_enables = lane[1] ? 4'b1100 : 4'b0011;
            default:    lane_enables = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_sram_subordinate_if.sv
// AHB-lite bus bundle between a manager (or bench) and one SRAM subordinate.
interface ahb_lite_sram_subordinate_if #(
    parameter int ADDR_WIDTH = ahb_lite_sram_subordinate_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = ahb_lite_sram_subordinate_pkg::DATA_WIDTH
);
    import ahb_lite_sram_subordinate_pkg::*;

    logic                   HSEL;
    logic [ADDR_WIDTH-1:0]  HADDR;
    logic [TRANS_WIDTH-1:0] HTRANS;
    logic                   HWRITE;
    logic [SIZE_WIDTH-1:0]  HSIZE;
    logic [BURST_WIDTH-1:0] HBURST;
    logic [PROT_WIDTH-1:0]  HPROT;
    logic [DATA_WIDTH-1:0]  HWDATA;
    logic                   HREADY;
    logic                   HREADYOUT;
    logic [RESP_WIDTH-1:0]  HRESP;
    logic [DATA_WIDTH-1:0]  HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/ahb_lite_sram_subordinate_array.sv
// MEM_DEPTH x 32 synchronous SRAM: byte-enabled write port and a registered read port.
module ahb_lite_sram_subordinate_array #(
    parameter int MEM_DEPTH = 256,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [3:0]       wbe,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ahb_lite_sram_subordinate.sv
// AHB-lite SRAM subordinate: transfer FSM with wait states, two-cycle ERROR, byte lanes
// and write-to-read forwarding in front of a synchronous array.
module ahb_lite_sram_subordinate #(
    parameter int ADDR_WIDTH  = ahb_lite_sram_subordinate_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = ahb_lite_sram_subordinate_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                        clk,
    input  logic                        HRESETn,
    ahb_lite_sram_subordinate_if.slave  bus
);
    import ahb_lite_sram_subordinate_pkg::*;

    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_WAIT = ST_WAIT;
    localparam logic [2:0] S_LAST = ST_LAST;
    localparam logic [2:0] S_ERR1 = ST_ERR1;
    localparam logic [2:0] S_ERR2 = ST_ERR2;

    logic [2:0]            state;
    logic [3:0]            cnt;
    logic [IDX_W-1:0]      addr_q;
    logic                  write_q;
    logic [3:0]            be_q;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [3:0]            fwd_be;

    logic                  accept;
    logic                  take;
    logic                  addr_err;
    logic [IDX_W-1:0]      haddr_idx;
    logic                  rd_en;
    logic [IDX_W-1:0]      rd_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_bus;

    assign unused_bus = ^{bus.HBURST, bus.HPROT};

    assign haddr_idx = bus.HADDR[IDX_W+1:2];
    assign accept    = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign take      = accept && (state == S_IDLE || state == S_LAST || state == S_ERR2);

    assign addr_err = (bus.HSIZE > HSIZE_WORD)
                   || (bus.HSIZE == HSIZE_HALF && bus.HADDR[0])
                   || (bus.HSIZE == HSIZE_WORD && bus.HADDR[1:0] != 2'b00)
                   || (|bus.HADDR[ADDR_WIDTH-1:IDX_W+2]);

    // Zero-wait reads fetch at accept; otherwise at the last wait cycle, after any prior write landed.
    assign rd_en   = (take && !bus.HWRITE && !addr_err && WAIT_STATES == 0)
                  || (state == S_WAIT && cnt == 4'd0 && !write_q);
    assign rd_addr = (state == S_WAIT) ? addr_q : haddr_idx;

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            be_q     <= 4'd0;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
            fwd_be   <= 4'd0;
        end else if (take) begin
            addr_q   <= haddr_idx;
            write_q  <= bus.HWRITE;
            be_q     <= lane_enables(bus.HSIZE, bus.HADDR[1:0]);
            fwd_hit  <= !bus.HWRITE && state == S_LAST && write_q && addr_q == haddr_idx;
            fwd_data <= bus.HWDATA;
            fwd_be   <= be_q;
            cnt      <= 4'(WAIT_STATES - 1);
            state    <= addr_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_LAST);
        end else begin
            case (state)
                S_WAIT:  if (cnt == 4'd0) state <= S_LAST;
                         else             cnt   <= cnt - 4'd1;
                S_ERR1:  state <= S_ERR2;
                default: state <= S_IDLE;
            endcase
        end
    end

    ahb_lite_sram_subordinate_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (state == S_LAST && write_q),
        .waddr (addr_q),
        .wbe   (be_q),
        .wdata (bus.HWDATA),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

    always_comb begin
        rd_word = mem_rdata;
        for (int b = 0; b < 4; b++) begin
            if (fwd_hit && fwd_be[b]) rd_word[8*b +: 8] = fwd_data[8*b +: 8];
        end
    end

    assign bus.HREADYOUT = !(state == S_WAIT || state == S_ERR1);
    assign bus.HRESP     = (state == S_ERR1 || state == S_ERR2);
    assign bus.HRDATA    = (state == S_LAST && !write_q) ? rd_word : '0;

endmodule

// File: tb/tb_ahb_lite_sram_subordinate.sv
// Bench for the AHB-lite SRAM subordinate: one zero-wait and one three-wait instance,
// driven by a pipelined manager model and checked against a word-array memory model.
module tb_ahb_lite_sram_subordinate;
    import ahb_lite_sram_subordinate_pkg::*;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        HRESETn;
    logic        cur;
    logic        h_sel;
    logic [31:0] h_addr;
    logic [1:0]  h_trans;
    logic        h_write;
    logic [2:0]  h_size;
    logic [2:0]  h_burst;
    logic [3:0]  h_prot;
    logic [31:0] h_wdata;

    logic        obs_rdy;
    logic        obs_resp;
    logic [31:0] obs_rdata;

    int          n_chk  = 0;
    int          n_fail = 0;
    xfer_t       q[$];
    logic [31:0] mem_m [2][256];

    always #5 clk = ~clk;

    ahb_lite_sram_subordinate_if bus0 ();
    ahb_lite_sram_subordinate_if bus1 ();

    assign bus0.HSEL   = h_sel & ~cur;
    assign bus1.HSEL   = h_sel & cur;
    assign bus0.HADDR  = h_addr;   assign bus1.HADDR  = h_addr;
    assign bus0.HTRANS = h_trans;  assign bus1.HTRANS = h_trans;
    assign bus0.HWRITE = h_write;  assign bus1.HWRITE = h_write;
    assign bus0.HSIZE  = h_size;   assign bus1.HSIZE  = h_size;
    assign bus0.HBURST = h_burst;  assign bus1.HBURST = h_burst;
    assign bus0.HPROT  = h_prot;   assign bus1.HPROT  = h_prot;
    assign bus0.HWDATA = h_wdata;  assign bus1.HWDATA = h_wdata;
    // Single-subordinate bus: the multiplexor returns each instance's own ready.
    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus1.HREADY = bus1.HREADYOUT;

    assign obs_rdy   = cur ? bus1.HREADYOUT : bus0.HREADYOUT;
    assign obs_resp  = cur ? bus1.HRESP     : bus0.HRESP;
    assign obs_rdata = cur ? bus1.HRDATA    : bus0.HRDATA;

    ahb_lite_sram_subordinate #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .HRESETn(HRESETn), .bus(bus0.slave)
    );
    ahb_lite_sram_subordinate #(.MEM_DEPTH(256), .WAIT_STATES(3)) dut1 (
        .clk(clk), .HRESETn(HRESETn), .bus(bus1.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input logic [2:0] size, input logic [31:0] addr);
        if (size > 3'd2) return 1'b1;
        if (size == 3'd1 && (addr % 2) != 0) return 1'b1;
        if (size == 3'd2 && (addr % 4) != 0) return 1'b1;
        return (addr / 4) >= 256;
    endfunction

    function automatic void mdl_write(input int dsel, input xfer_t x);
        int w;
        int off;
        int nb;
        w   = int'(x.addr / 4);
        off = int'(x.addr % 4);
        nb  = 1 << x.size;
        for (int b = off; b < off + nb; b++) mem_m[dsel][w][8*b +: 8] = x.wdata[8*b +: 8];
    endfunction

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
        return x;
    endfunction

    // Issue q back to back; every cycle compares the bus outputs with the expected response.
    task automatic run();
        int    i     = 0;
        bit    dp    = 1'b0;
        bit    derr  = 1'b0;
        int    k     = 0;
        int    lat   = 0;
        int    guard = 0;
        int    ws;
        xfer_t d     = '0;
        logic  exp_rdy;
        logic  exp_resp;
        logic [31:0] exp_rd;
        ws = cur ? 3 : 0;
        while ((i < q.size() || dp) && guard < 4000) begin
            @(negedge clk);
            guard++;
            h_wdata = (dp && d.wr) ? d.wdata : $urandom;
            h_burst = 3'($urandom);
            h_prot  = 4'($urandom);
            if (i < q.size()) begin
                h_sel = q[i].sel; h_trans = q[i].trans; h_write = q[i].wr;
                h_size = q[i].size; h_addr = q[i].addr;
            end else begin
                h_sel = 1'b0; h_trans = HTRANS_IDLE;
            end
            exp_rdy  = dp ? (k >= lat) : 1'b1;
            exp_resp = dp ? derr : 1'b0;
            exp_rd   = (dp && !derr && !d.wr && k == lat) ? mem_m[cur][d.addr / 4] : 32'd0;
            check(cur ? "hreadyout_ws3" : "hreadyout_ws0", 32'(obs_rdy), 32'(exp_rdy));
            check(cur ? "hresp_ws3" : "hresp_ws0", 32'(obs_resp), 32'(exp_resp));
            check(cur ? "hrdata_ws3" : "hrdata_ws0", obs_rdata, exp_rd);
            if (obs_rdy) begin
                if (dp && !derr && d.wr) mdl_write(int'(cur), d);
                dp = 1'b0;
                if (i < q.size()) begin
                    if (q[i].sel && q[i].trans[1]) begin
                        dp   = 1'b1;
                        d    = q[i];
                        derr = is_err(d.size, d.addr);
                        lat  = derr ? 1 : ws;
                        k    = 0;
                    end
                    i++;
                end
            end else begin
                k++;
            end
        end
        check("run_complete", 32'(guard < 4000), 32'd1);
        h_sel = 1'b0; h_trans = HTRANS_IDLE;
        q.delete();
    endtask

    initial begin
        HRESETn = 1'b0; cur = 1'b0;
        h_sel = 1'b0; h_addr = '0; h_trans = HTRANS_IDLE; h_write = 1'b0;
        h_size = 3'd0; h_burst = 3'd0; h_prot = 4'd0; h_wdata = '0;
        #1;
        check("reset_hreadyout0", 32'(bus0.HREADYOUT), 32'd1);
        check("reset_hresp0", 32'(bus0.HRESP), 32'd0);
        check("reset_hrdata0", bus0.HRDATA, 32'd0);
        check("reset_hreadyout1", 32'(bus1.HREADYOUT), 32'd1);
        check("reset_hresp1", 32'(bus1.HRESP), 32'd0);
        check("reset_hrdata1", bus1.HRDATA, 32'd0);
        repeat (2) @(negedge clk);
        HRESETn = 1'b1;

        // Known contents for every word the bench reads later.
        for (int dsel = 0; dsel < 2; dsel++) begin
            cur = 1'(dsel);
            for (int w = 0; w < 64; w++) q.push_back(mk(1, HTRANS_NONSEQ, 1, 3'd2, 32'(w * 4), $urandom));
            run();
        end

        cur = 1'b0;
        q.push_back(mk(1, HTRANS_NONSEQ, 1, 3'd2, 32'h10, 32'hDEADBEEF));
        q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h10, 32'h0));
        run();

        for (int dsel = 0; dsel < 2; dsel++) begin
            cur = 1'(dsel);
            q.push_back(mk(1, HTRANS_NONSEQ, 1, 3'd2, 32'h10, 32'h11223344));
            q.push_back(mk(1, HTRANS_NONSEQ, 1, 3'd0, 32'h13, 32'hAA000000));
            q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h10, 32'h0));
            q.push_back(mk(1, HTRANS_NONSEQ, 1, 3'd1, 32'h12, 32'h55660000));
            q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h10, 32'h0));
            run();
        end
        check("byte_half_model", mem_m[1][4], 32'h55663344);

        cur = 1'b1;
        q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h20, 32'h0));
        q.push_back(mk(1, HTRANS_SEQ,    0, 3'd2, 32'h24, 32'h0));
        q.push_back(mk(1, HTRANS_NONSEQ, 1, 3'd2, 32'h20, 32'h0BADCAFE));
        q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h20, 32'h0));
        run();

        for (int dsel = 0; dsel < 2; dsel++) begin
            cur = 1'(dsel);
            q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h02, 32'h0));
            q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h400, 32'h0));
            q.push_back(mk(1, HTRANS_NONSEQ, 1, 3'd2, 32'h12, 32'hFFFFFFFF));
            q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h10, 32'h0));
            q.push_back(mk(1, HTRANS_NONSEQ, 1, 3'd1, 32'h01, 32'hFFFFFFFF));
            q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd3, 32'h10, 32'h0));
            q.push_back(mk(1, HTRANS_NONSEQ, 1, 3'd0, 32'h400, 32'hFFFFFFFF));
            q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h00, 32'h0));
            q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h10, 32'h0));
            run();

            q.push_back(mk(1, HTRANS_IDLE,   1, 3'd2, 32'h10, 32'h12345678));
            q.push_back(mk(1, HTRANS_BUSY,   1, 3'd2, 32'h10, 32'h12345678));
            q.push_back(mk(0, HTRANS_NONSEQ, 1, 3'd2, 32'h10, 32'h12345678));
            q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h10, 32'h0));
            run();
        end

        // Reset in the middle of a wait-stated write must drop the write.
        cur = 1'b1;
        @(negedge clk);
        h_sel = 1'b1; h_trans = HTRANS_NONSEQ; h_write = 1'b1; h_size = 3'd2; h_addr = 32'h40;
        @(negedge clk);
        h_sel = 1'b0; h_trans = HTRANS_IDLE; h_wdata = 32'hCAFEF00D;
        check("rst_mid_wait", 32'(obs_rdy), 32'd0);
        #2 HRESETn = 1'b0;
        #1;
        check("rst_async_hreadyout", 32'(obs_rdy), 32'd1);
        check("rst_async_hresp", 32'(obs_resp), 32'd0);
        check("rst_async_hrdata", obs_rdata, 32'd0);
        @(negedge clk);
        HRESETn = 1'b1;
        q.push_back(mk(1, HTRANS_NONSEQ, 0, 3'd2, 32'h40, 32'h0));
        run();

        for (int dsel = 0; dsel < 2; dsel++) begin
            cur = 1'(dsel);
            for (int n = 0; n < 200; n++) begin
                xfer_t x;
                x.sel   = ($urandom_range(0, 7) != 0);
                x.trans = 2'($urandom_range(0, 3));
                x.wr    = 1'($urandom);
                x.size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                x.addr  = ($urandom_range(0, 15) == 0) ? 32'(1024 + $urandom_range(0, 4095))
                                                       : 32'($urandom_range(0, 127));
                if (x.size <= 3'd2 && $urandom_range(0, 3) != 0)
                    x.addr = x.addr & ~(32'(1 << x.size) - 32'd1);
                x.wdata = $urandom;
                q.push_back(x);
            end
            run();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
